ff_mult_serial: RTL and testbench
=================================

Name: ff_mult_serial

Overview:
Bit-serial GF(2^NUM_BITS) multiplier: sits directly upstream of ff_add, producing finite-field products that the adder stage XOR-combines. Uses MSB-first Horner (shift-and-add) with modular reduction by a fixed irreducible polynomial. One product per NUM_BITS cycles, start/done handshake.

Parameters:
NUM_BITS, 8, field width m; operands/result are m bits
POLY, 8'h1B, reduction polynomial low m bits (implicit x^m term); default = AES x^8+x^4+x^3+x+1

Ports:
clk  input  1  system clock, rising-edge
n_rst  input  1  asynchronous active-low reset
start  input  1  request; sampled only when not busy
op_a  input  NUM_BITS  multiplicand, latched when start accepted
op_b  input  NUM_BITS  multiplier, latched when start accepted
busy  output  1  high while state CALC
done  output  1  one-cycle pulse, result valid
result  output  NUM_BITS  product op_a*op_b mod POLY, held until next done

Behaviour:
- Reset (n_rst low, async): state IDLE, busy=0, done=0, result=0, internal a/b/acc/count=0. Reset mid-operation aborts; no done is produced for the aborted op.
- States: IDLE, CALC, DONE.
- IDLE: start=1 at rising edge -> latch a<=op_a, b<=op_b, acc<=0, count<=0, go CALC. start=0 -> stay.
- CALC: each edge one iteration:
  - xt = {acc[m-2:0],1'b0} ^ (acc[m-1] ? POLY : 0)  (xtime, reduction)
  - acc <= xt ^ (b[m-1] ? a : 0)  (XOR accumulate, same function as ff_add)
  - b <= b << 1; count <= count+1
  - on iteration with count==NUM_BITS-1: result <= final acc value, go DONE.
- DONE: done=1 for exactly this cycle; busy=0. Next edge: start=1 -> accept new operands, go CALC (back-to-back allowed); else IDLE.
- Latency: start sampled at edge E0 -> done high in cycle after edge E(NUM_BITS); for default, 8 cycles. Throughput: one op per NUM_BITS+1 cycles back-to-back.
- start while CALC ignored; operands not re-latched; in-flight op unaffected.
- op_a/op_b changes after acceptance have no effect.
- busy = (state==CALC); done = (state==DONE); both registered-state decodes, glitch-free.
- result changes only on the edge entering DONE; stable otherwise, including during later CALC.
- count width ceil(log2(NUM_BITS))+1; no wrap within an op.
- All arithmetic is carry-free (XOR); no integer addition on data path.

Test Plan:
- Reset then idle: n_rst low -> busy=0, done=0, result=0x00; start=0 for 20 cycles -> outputs unchanged.
- AES vector: op_a=0x57, op_b=0x83, start pulse -> busy for 8 cycles, done single pulse 8 cycles after start edge, result=0xC1; second op 0x57*0x13 -> 0xFE.
- Reduction/identity corners: 0x02*0x80 -> 0x1B; 0x01*0xA5 -> 0xA5; 0x00*0xFF -> 0x00; 0xFF*0x00 -> 0x00.
- Back-to-back: start held high continuously with 0x53*0xCA then 0x03*0x03 presented at DONE cycle -> results 0x01 then 0x05, done pulses 9 cycles apart.
- Start-while-busy: accept 0x57*0x83, pulse start with 0x01*0x01 at cycle 3 of CALC -> ignored, result=0xC1, only one done.
- Reset mid-op: assert n_rst low at CALC cycle 4 -> immediately busy=0, result=0x00, no done; after release, new 0x57*0x83 -> 0xC1.

Source files
------------

// File: rtl/ff_mult_serial.sv
// Bit-serial GF(2^NUM_BITS) multiplier, MSB-first Horner with reduction by POLY.
// One product per NUM_BITS cycles, start/done handshake, result held until the next done.
module ff_mult_serial #(
  parameter int                  NUM_BITS = 8,
  parameter logic [NUM_BITS-1:0] POLY     = 8'h1B
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] op_a,
  input  logic [NUM_BITS-1:0] op_b,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] result
);

  localparam int CW = $clog2(NUM_BITS) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [NUM_BITS-1:0] r_a;
  logic [NUM_BITS-1:0] r_b;
  logic [NUM_BITS-1:0] r_acc;
  logic [NUM_BITS-1:0] r_result;
  logic [CW-1:0]       r_count;
  logic [NUM_BITS-1:0] w_xt;
  logic [NUM_BITS-1:0] w_acc_next;
  logic                w_last;
  logic                w_accept;

  // Multiply accumulator by x (with reduction), then fold in a when the current multiplier bit is set.
  assign w_xt       = {r_acc[NUM_BITS-2:0], 1'b0} ^ (r_acc[NUM_BITS-1] ? POLY : '0);
  assign w_acc_next = w_xt ^ (r_b[NUM_BITS-1] ? r_a : '0);
  assign w_last     = (r_count == CW'(NUM_BITS - 1));
  assign w_accept   = start && (r_state != S_CALC);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_CALC;
      S_CALC:  if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = start ? S_CALC : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_a     <= op_a;
      r_b     <= op_b;
      r_acc   <= '0;
      r_count <= '0;
    end else if (r_state == S_CALC) begin
      r_acc   <= w_acc_next;
      r_b     <= {r_b[NUM_BITS-2:0], 1'b0};
      r_count <= r_count + 1'b1;
      if (w_last) r_result <= w_acc_next;
    end
  end

  assign busy   = (r_state == S_CALC);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule

// File: tb/tb_ff_mult_serial.sv
// Self-checking bench for ff_mult_serial: directed corners from the field arithmetic
// plus randomized products checked against a plain GF(2^8) multiply model.
module tb_ff_mult_serial;

  localparam int          NUM_BITS = 8;
  localparam logic [7:0]  POLY     = 8'h1B;

  logic       clk;
  logic       n_rst;
  logic       start;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       busy;
  logic       done;
  logic [7:0] result;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  ff_mult_serial #(.NUM_BITS(NUM_BITS), .POLY(POLY)) dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // LSB-first peasant multiplication: independent of the DUT's MSB-first iteration.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < NUM_BITS; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ POLY;
      b  = b >> 1;
    end
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp,
                       input string tag);
    int cyc;
    int busy_cyc;
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; op_a = 8'($urandom); op_b = 8'($urandom);
    cyc = 0; busy_cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) busy_cyc++;
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, cyc, NUM_BITS);
    check({tag, " busy_cycles"}, busy_cyc, NUM_BITS);
    check({tag, " result"}, {24'd0, result}, {24'd0, exp});
    check({tag, " busy_in_done"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, " result_held"}, {24'd0, result}, {24'd0, exp});
    $display("op %s: 0x%02h * 0x%02h -> 0x%02h (expected 0x%02h)", tag, a, b, result, exp);
  endtask

  initial begin
    int         cnt;
    int         d0;
    logic [7:0] ra;
    logic [7:0] rb;

    n_rst = 1'b0; start = 1'b0; op_a = 8'h00; op_b = 8'h00;
    repeat (3) @(negedge clk);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst result", {24'd0, result}, 32'd0);
    n_rst = 1'b1;
    repeat (20) @(negedge clk);
    check("idle busy", {31'd0, busy}, 32'd0);
    check("idle result", {24'd0, result}, 32'd0);
    check("idle no_done", done_cnt, 0);

    do_op(8'h57, 8'h83, 8'hC1, "aes");
    do_op(8'h57, 8'h13, 8'hFE, "aes2");
    do_op(8'h02, 8'h80, 8'h1B, "reduce");
    do_op(8'h01, 8'hA5, 8'hA5, "ident");
    do_op(8'h00, 8'hFF, 8'h00, "zero_a");
    do_op(8'hFF, 8'h00, 8'h00, "zero_b");

    // Back-to-back with start held high; second operands appear in the DONE cycle.
    @(negedge clk);
    start = 1'b1; op_a = 8'h53; op_b = 8'hCA;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (done !== 1'b1 && cnt < 40);
    check("b2b first latency", cnt, NUM_BITS + 1);
    check("b2b first result", {24'd0, result}, 32'h01);
    op_a = 8'h03; op_b = 8'h03;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (done !== 1'b1 && cnt < 40);
    start = 1'b0;
    check("b2b done spacing", cnt, NUM_BITS + 1);
    check("b2b second result", {24'd0, result}, 32'h05);
    $display("op b2b: 0x53*0xCA then 0x03*0x03, spacing %0d, result 0x%02h", cnt, result);
    repeat (2) @(negedge clk);

    // Start pulse during CALC must be ignored.
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; op_a = 8'h57; op_b = 8'h83;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; op_a = 8'h01; op_b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("busy_start done_count", done_cnt - d0, 1);
    check("busy_start result", {24'd0, result}, 32'hC1);
    check("busy_start idle", {31'd0, busy}, 32'd0);
    $display("op busy_start: 0x57*0x83 with stray start, result 0x%02h", result);

    // Reset in the middle of an operation aborts it without a done.
    @(negedge clk);
    start = 1'b1; op_a = 8'h12; op_b = 8'h34;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst pre busy", {31'd0, busy}, 32'd1);
    #1 n_rst = 1'b0;
    #1;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    check("midrst result", {24'd0, result}, 32'd0);
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst no_done", done_cnt - d0, 0);
    check("midrst result_stays", {24'd0, result}, 32'd0);
    $display("op midrst: aborted, result 0x%02h", result);
    do_op(8'h57, 8'h83, 8'hC1, "after_rst");

    for (int i = 0; i < 25; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_op(ra, rb, gf_mul(ra, rb), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
